operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage directly upstream of the 16-bit ALU. Holds the 8-entry general register file and carry/zero flags. On an issue it reads two source registers, with same-cycle write bypass, and registers them with the opcode into a one-deep pipeline register that drives the ALU's A, B and ALU_Code inputs. ALU results come back through the write port (writeback) and the flag-update inputs.

## Interface
Parameters:
- DATA_WIDTH, 16, register/operand width
- ADDR_WIDTH, 3, register index width (2^ADDR_WIDTH registers)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- Issue  input  1  request to fetch operands for one instruction
- Stall  input  1  hold the pipeline register (downstream not accepting)
- Rs_A  input  ADDR_WIDTH  source register for operand A
- Rs_B  input  ADDR_WIDTH  source register for operand B
- Rd_In  input  ADDR_WIDTH  destination register, carried with the instruction
- Op_In  input  3  ALU operation code, carried with the instruction
- Wr_En  input  1  register write enable (writeback)
- Wr_Addr  input  ADDR_WIDTH  write destination
- Wr_Data  input  DATA_WIDTH  write data (ALU result)
- Flag_En  input  1  update carry/zero flags
- Carry_In  input  1  carry from ALU
- Zero_In  input  1  zero indication from ALU
- A  output  DATA_WIDTH  registered operand A to ALU
- B  output  DATA_WIDTH  registered operand B to ALU
- ALU_Code  output  3  registered opcode to ALU
- Rd_Out  output  ADDR_WIDTH  registered destination index
- Op_Valid  output  1  A/B/ALU_Code/Rd_Out hold a valid instruction
- Carry_Flag  output  1  stored carry flag
- Zero_Flag  output  1  stored zero flag

## Operation
- Register file: 2^ADDR_WIDTH × DATA_WIDTH.
  - R0 always reads 0; writes to R0 are discarded.
  - All other registers are writable.
- Write: on a rising edge with Wr_En=1 and Wr_Addr≠0, reg[Wr_Addr] ← Wr_Data.
- Combinational read of src_X (X = A or B):
  - 0 if Rs_X=0.
  - Otherwise Wr_Data if Wr_En=1 and Wr_Addr=Rs_X (write bypass).
  - Otherwise reg[Rs_X].
- Pipeline register, evaluated at each rising edge:
  - Stall=1: A, B, ALU_Code, Rd_Out and Op_Valid hold. Writes and flag updates still proceed.
  - Stall=0, Issue=1: A←src_A, B←src_B, ALU_Code←Op_In, Rd_Out←Rd_In, Op_Valid←1.
  - Stall=0, Issue=0: Op_Valid←0. A, B, ALU_Code and Rd_Out hold their last values.
- Issue is ignored while Stall=1. The requester keeps Issue asserted until a cycle with Stall=0.
- Stale-operand rule: a held (stalled) operand is not refreshed by a later write to its source register. The writeback path does not write a register that an in-flight instruction reads.
- Flags: on a rising edge with Flag_En=1, Carry_Flag←Carry_In and Zero_Flag←Zero_In. Otherwise they hold. Flag_En is independent of Stall.
- Rs_A=Rs_B is legal; both operands get the same value, bypass included.
- Wr_Addr=0 with Wr_En=1 never bypasses; operand reads 0.

## Timing
- Reset (rst_n=0, asynchronous assert, any time): all registers, A, B, ALU_Code, Rd_Out, Op_Valid, Carry_Flag and Zero_Flag → 0 immediately.
  - An issue in flight when reset asserts is lost; no partial update.
- Reset deassertion is synchronous to clk by the system. The first edge with rst_n=1 is a normal cycle.
- Issue-to-operand latency: 1 cycle. Issue sampled at edge N gives A/B/ALU_Code valid with Op_Valid=1 after edge N.
- Write-to-read: a write at edge N is visible to an Issue in the same cycle via bypass, and from register storage after edge N.
- Flag latency: 1 cycle from Flag_En sample to Carry_Flag/Zero_Flag.
- Throughput: one instruction per cycle when Stall=0.
- No combinational path from any input to any output. All outputs are register outputs.

## Test plan
- Reset: drive rst_n=0 mid-cycle after loading registers → all outputs 0 immediately. After release, Issue Rs_A=3, Rs_B=5 → A=0, B=0, Op_Valid=1.
- Write then read: write R3=16'h1234 and R5=16'hFFFF. Next cycle Issue Rs_A=3, Rs_B=5, Op_In=3'b001, Rd_In=2 → after 1 edge A=16'h1234, B=16'hFFFF, ALU_Code=3'b001, Rd_Out=2, Op_Valid=1.
- Bypass and R0: in one cycle Wr_En=1, Wr_Addr=4, Wr_Data=16'hA5A5, Issue Rs_A=4, Rs_B=4 → A=B=16'hA5A5. Then write R0=16'h7777 and Issue Rs_A=0 → A=16'h0000.
- Stall: capture A=16'h0011, then hold Stall=1 for 3 cycles with Issue=1, Rs_A=6, and write R6=16'h0022 → A stays 16'h0011, Op_Valid stays 1. Release Stall → A=16'h0022 after the next edge.
- Bubble: Issue=0, Stall=0 → Op_Valid=0 after 1 edge, A/B unchanged.
- Flags: Flag_En=1, Carry_In=1, Zero_In=0, then Flag_En=0 with inputs toggling → Carry_Flag=1, Zero_Flag=0 held. Flag_En=1, Zero_In=1 during Stall=1 → Zero_Flag=1.

Source files
------------

// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bundle: issue request, writeback port,
// flag update and the registered operand outputs to the ALU.
interface operand_fetch_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  Issue;
  logic                  Stall;
  logic [ADDR_WIDTH-1:0] Rs_A;
  logic [ADDR_WIDTH-1:0] Rs_B;
  logic [ADDR_WIDTH-1:0] Rd_In;
  logic [2:0]            Op_In;
  logic                  Wr_En;
  logic [ADDR_WIDTH-1:0] Wr_Addr;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  Flag_En;
  logic                  Carry_In;
  logic                  Zero_In;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [2:0]            ALU_Code;
  logic [ADDR_WIDTH-1:0] Rd_Out;
  logic                  Op_Valid;
  logic                  Carry_Flag;
  logic                  Zero_Flag;

  modport master (
    output Issue, Stall, Rs_A, Rs_B, Rd_In, Op_In,
    output Wr_En, Wr_Addr, Wr_Data,
    output Flag_En, Carry_In, Zero_In,
    input  A, B, ALU_Code, Rd_Out, Op_Valid,
    input  Carry_Flag, Zero_Flag
  );

  modport slave (
    input  Issue, Stall, Rs_A, Rs_B, Rd_In, Op_In,
    input  Wr_En, Wr_Addr, Wr_Data,
    input  Flag_En, Carry_In, Zero_In,
    output A, B, ALU_Code, Rd_Out, Op_Valid,
    output Carry_Flag, Zero_Flag
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: 8x16 register file with write bypass, flags and
// a one-deep pipeline register feeding the ALU.
module operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input logic clk,
  input logic rst_n,
  operand_fetch_if.slave bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic [2:0]            code;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] a;
  } of_ex_t;

  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] src_b;
  of_ex_t                pipe_d;
  of_ex_t                pipe_q;
  logic                  carry_d;
  logic                  carry_q;
  logic                  zero_d;
  logic                  zero_q;
  logic                  wr_ok;

  // R0 is never written, so the write path excludes it entirely
  assign wr_ok = bus.Wr_En && (bus.Wr_Addr != '0);

  always_comb begin
    src_a = rf_q[bus.Rs_A];
    if (bus.Rs_A == '0)
      src_a = '0;
    else if (wr_ok && (bus.Wr_Addr == bus.Rs_A))
      src_a = bus.Wr_Data;
  end

  always_comb begin
    src_b = rf_q[bus.Rs_B];
    if (bus.Rs_B == '0)
      src_b = '0;
    else if (wr_ok && (bus.Wr_Addr == bus.Rs_B))
      src_b = bus.Wr_Data;
  end

  always_comb begin
    pipe_d = pipe_q;
    if (!bus.Stall) begin
      if (bus.Issue) begin
        pipe_d.a     = src_a;
        pipe_d.b     = src_b;
        pipe_d.code  = bus.Op_In;
        pipe_d.rd    = bus.Rd_In;
        pipe_d.valid = 1'b1;
      end else begin
        pipe_d.valid = 1'b0;
      end
    end
  end

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (bus.Flag_En) begin
      carry_d = bus.Carry_In;
      zero_d  = bus.Zero_In;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf_q[i] <= '0;
    end else if (wr_ok) begin
      rf_q[bus.Wr_Addr] <= bus.Wr_Data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.A          = pipe_q.a;
  assign bus.B          = pipe_q.b;
  assign bus.ALU_Code   = pipe_q.code;
  assign bus.Rd_Out     = pipe_q.rd;
  assign bus.Op_Valid   = pipe_q.valid;
  assign bus.Carry_Flag = carry_q;
  assign bus.Zero_Flag  = zero_q;
endmodule
